// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes and pedestrian state encoding shared across the intersection.
package traffic_pkg;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  typedef enum logic [1:0] {PED_DONT_WALK, PED_WALK, PED_FLASH} ped_state_t;
endpackage

// File: rtl/button_sync.sv
// button_sync: two-flop synchroniser for the raw push-button plus a rising-edge pulse.
module button_sync (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);
  logic s1_q, s2_q, s3_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= button;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign pulse = s2_q & ~s3_q;
endmodule

// File: rtl/pedestrian_signal_controller.sv
// pedestrian_signal_controller: WALK / flashing clearance / DON'T WALK sequencing,
// gated on vehicle red entry, with abort when red ends early.
module pedestrian_signal_controller
  import traffic_pkg::*;
#(
  parameter int WALK_TICKS  = 10,
  parameter int FLASH_TICKS = 5,
  parameter int TICK_DIV    = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             abort,
  output logic             fault
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_HALF = PW'(TICK_DIV / 2);
  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_TICKS);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_TICKS);

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             red_prev_q, red_prev_d;
  logic             req_q, req_d;
  logic             abort_q, abort_d;
  logic             fault_q, fault_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             btn_pulse, is_red, legal, red_entry, wrap, expire;

  button_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .pulse  (btn_pulse)
  );

  assign is_red    = light == LIGHT_RED;
  assign legal     = is_red || light == LIGHT_YELLOW || light == LIGHT_GREEN;
  assign red_entry = is_red & ~red_prev_q;
  assign wrap      = pre_q == PRE_MAX;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    abort_d    = 1'b0;
    expire     = 1'b0;
    red_prev_d = is_red;
    fault_d    = fault_q | ~legal;
    case (state_q)
      PED_DONT_WALK: begin
        if (red_entry && (req_q || btn_pulse)) begin
          state_d = PED_WALK;
          cnt_d   = WALK_LD;
          pre_d   = '0;
        end
      end
      PED_WALK, PED_FLASH: begin
        // Losing red always wins, even on the tick that would end the phase.
        if (!is_red) begin
          state_d = PED_DONT_WALK;
          abort_d = 1'b1;
          cnt_d   = '0;
          pre_d   = '0;
        end else begin
          pre_d = wrap ? '0 : pre_q + PW'(1);
          if (wrap) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = (state_q == PED_WALK) ? PED_FLASH : PED_DONT_WALK;
              cnt_d   = (state_q == PED_WALK) ? FLASH_LD : '0;
              expire  = state_q == PED_FLASH;
            end
          end
        end
      end
      default: begin
        state_d = PED_DONT_WALK;
        cnt_d   = '0;
        pre_d   = '0;
      end
    endcase
    req_d       = btn_pulse | (req_q & ~expire);
    walk_d      = state_d == PED_WALK;
    dont_walk_d = state_d == PED_DONT_WALK || (state_d == PED_FLASH && pre_d < PRE_HALF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= PED_DONT_WALK;
      cnt_q       <= '0;
      pre_q       <= '0;
      red_prev_q  <= 1'b0;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      fault_q     <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      red_prev_q  <= red_prev_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      fault_q     <= fault_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = cnt_q;
  assign req_pending = req_q;
  assign abort       = abort_q;
  assign fault       = fault_q;
endmodule

// File: tb/tb_pedestrian_signal_controller.sv
// tb_pedestrian_signal_controller: directed scenarios with hand-computed expectations.
module tb_pedestrian_signal_controller;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] light = GRN;
  logic       button = 1'b0;
  logic       walk, dont_walk, req_pending, abort, fault;
  logic [7:0] countdown;
  int tests = 0;
  int fails = 0;

  pedestrian_signal_controller #(
    .WALK_TICKS(3), .FLASH_TICKS(2), .TICK_DIV(4), .CNT_W(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .light       (light),
    .button      (button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .abort       (abort),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press();
    button = 1'b1;
    tick(4);
    button = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    light = GRN;
    tick(2);
    tests++;
    if ({walk, dont_walk, countdown, req_pending, abort, fault} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_held: w=%b dw=%b cd=%0d req=%b ab=%b f=%b, want 0 1 0 0 0 0", walk, dont_walk, countdown, req_pending, abort, fault);
    end
    reset = 1'b1;
    tick(3);
    tests++;
    if ({walk, dont_walk, countdown, req_pending, abort, fault} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_released: w=%b dw=%b cd=%0d req=%b ab=%b f=%b, want 0 1 0 0 0 0", walk, dont_walk, countdown, req_pending, abort, fault);
    end
  endtask

  task automatic test_walk_cycle();
    light = GRN;
    press();
    tests++;
    if (req_pending !== 1'b1) begin
      fails++;
      $display("FAIL button_req: req=%b want 1", req_pending);
    end
    light = RED;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      tests++;
      if (walk !== 1'b1 || dont_walk !== 1'b0 || countdown !== 8'(3 - (k - 1) / 4)) begin
        fails++;
        $display("FAIL walk_phase k=%0d: w=%b dw=%b cd=%0d, want 1 0 %0d", k, walk, dont_walk, countdown, 3 - (k - 1) / 4);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      tests++;
      if (walk !== 1'b0 || dont_walk !== (((k - 1) % 4) < 2) || countdown !== 8'(2 - (k - 1) / 4)) begin
        fails++;
        $display("FAIL flash_phase k=%0d: w=%b dw=%b cd=%0d, want 0 %b %0d", k, walk, dont_walk, countdown, ((k - 1) % 4) < 2, 2 - (k - 1) / 4);
      end
    end
    tick(1);
    tests++;
    if (walk !== 1'b0 || dont_walk !== 1'b1 || req_pending !== 1'b0 || countdown !== 8'd0) begin
      fails++;
      $display("FAIL walk_done: w=%b dw=%b req=%b cd=%0d, want 0 1 0 0", walk, dont_walk, req_pending, countdown);
    end
    tick(19);
    tests++;
    if (walk !== 1'b0 || dont_walk !== 1'b1) begin
      fails++;
      $display("FAIL red_hold_after: w=%b dw=%b, want 0 1", walk, dont_walk);
    end
  endtask

  task automatic test_no_request();
    light = GRN;
    tick(2);
    light = RED;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      tests++;
      if (walk !== 1'b0 || countdown !== 8'd0 || dont_walk !== 1'b1) begin
        fails++;
        $display("FAIL no_request k=%0d: w=%b dw=%b cd=%0d, want 0 1 0", k, walk, dont_walk, countdown);
      end
    end
  endtask

  task automatic test_abort();
    light = GRN;
    tick(1);
    press();
    light = RED;
    tick(1);
    tests++;
    if (walk !== 1'b1 || countdown !== 8'd3) begin
      fails++;
      $display("FAIL abort_walk_start: w=%b cd=%0d, want 1 3", walk, countdown);
    end
    tick(4);
    light = GRN;
    tick(1);
    tests++;
    if ({walk, dont_walk, abort, req_pending, countdown} !== {1'b0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
      fails++;
      $display("FAIL abort_pulse: w=%b dw=%b ab=%b req=%b cd=%0d, want 0 1 1 1 0", walk, dont_walk, abort, req_pending, countdown);
    end
    tick(1);
    tests++;
    if (abort !== 1'b0 || req_pending !== 1'b1) begin
      fails++;
      $display("FAIL abort_one_cycle: ab=%b req=%b, want 0 1", abort, req_pending);
    end
    light = RED;
    tick(1);
    tests++;
    if (walk !== 1'b1 || countdown !== 8'd3) begin
      fails++;
      $display("FAIL abort_retry: w=%b cd=%0d, want 1 3", walk, countdown);
    end
    tick(20);
    tests++;
    if (walk !== 1'b0 || dont_walk !== 1'b1 || req_pending !== 1'b0) begin
      fails++;
      $display("FAIL abort_retry_done: w=%b dw=%b req=%b, want 0 1 0", walk, dont_walk, req_pending);
    end
  endtask

  task automatic test_button_during_red();
    light = RED;
    press();
    tests++;
    if (req_pending !== 1'b1) begin
      fails++;
      $display("FAIL red_req_latched: req=%b want 1", req_pending);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1);
      tests++;
      if (walk !== 1'b0) begin
        fails++;
        $display("FAIL red_no_walk k=%0d: w=%b want 0", k, walk);
      end
    end
    light = GRN;
    tick(2);
    light = YEL;
    tick(1);
    light = RED;
    tick(1);
    tests++;
    if (walk !== 1'b1 || countdown !== 8'd3) begin
      fails++;
      $display("FAIL red_next_entry: w=%b cd=%0d, want 1 3", walk, countdown);
    end
    tick(20);
    tests++;
    if (req_pending !== 1'b0 || dont_walk !== 1'b1) begin
      fails++;
      $display("FAIL red_next_done: req=%b dw=%b, want 0 1", req_pending, dont_walk);
    end
  endtask

  task automatic test_back_to_back();
    light = GRN;
    tick(1);
    press();
    light = RED;
    tick(18);
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tests++;
    if (walk !== 1'b0 || dont_walk !== 1'b1 || req_pending !== 1'b1) begin
      fails++;
      $display("FAIL set_over_clear: w=%b dw=%b req=%b, want 0 1 1", walk, dont_walk, req_pending);
    end
    light = GRN;
    tick(2);
    light = RED;
    tick(1);
    tests++;
    if (walk !== 1'b1) begin
      fails++;
      $display("FAIL rearmed_walk: w=%b want 1", walk);
    end
    tick(20);
  endtask

  task automatic test_fault();
    light = 3'b110;
    tick(1);
    tests++;
    if (fault !== 1'b1 || walk !== 1'b0) begin
      fault_msg: begin
        fails++;
        $display("FAIL fault_set: f=%b w=%b, want 1 0", fault, walk);
      end
    end
    light = GRN;
    tick(3);
    tests++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_sticky: f=%b want 1", fault);
    end
    press();
    light = RED;
    tick(3);
    tests++;
    if (walk !== 1'b1 || req_pending !== 1'b1) begin
      fails++;
      $display("FAIL fault_walk: w=%b req=%b, want 1 1", walk, req_pending);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({walk, dont_walk, countdown, req_pending, abort, fault} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: w=%b dw=%b cd=%0d req=%b ab=%b f=%b, want 0 1 0 0 0 0", walk, dont_walk, countdown, req_pending, abort, fault);
    end
    tick(2);
    light = GRN;
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_walk_cycle();
    test_no_request();
    test_abort();
    test_button_during_red();
    test_back_to_back();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pedestrian_signal_controller.md
# pedestrian_signal_controller

Pedestrian crossing controller downstream of the vehicle signal FSM. It consumes the 3-bit vehicle `light` code, latches a pedestrian push-button request, and drives the WALK / DON'T WALK lamps. A walk phase runs only inside a vehicle red phase, followed by a flashing clearance phase with a tick countdown. If the vehicle red ends early, the phase is aborted safely.

## Interface
- `WALK_TICKS`, 10: length of steady WALK, in ticks
- `FLASH_TICKS`, 5: length of flashing clearance, in ticks
- `TICK_DIV`, 10: clock cycles per tick; must be even and ≥ 2
- `CNT_W`, 8: countdown width; must hold max(WALK_TICKS, FLASH_TICKS)

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `light`  in  3  vehicle light, synchronous to `clock`; codes 3'b100 red, 3'b010 yellow, 3'b001 green
- `button`  in  1  raw pedestrian push-button, asynchronous
- `walk`  out  1  WALK lamp
- `dont_walk`  out  1  DON'T WALK lamp
- `countdown`  out  CNT_W  ticks remaining in the current WALK/FLASH phase; 0 in DONT_WALK
- `req_pending`  out  1  request latched, not yet served
- `abort`  out  1  one-cycle pulse when a WALK/FLASH phase is cut short
- `fault`  out  1  sticky flag: an illegal `light` code was seen

## Operation
- Reset (`reset`=0): state DONT_WALK; `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0, `abort`=0, `fault`=0; synchroniser, prescaler and `light` history cleared.
- `button` path: 2-flop synchroniser, then rising-edge detect. An edge sets `req_pending`. Holding the button gives one request only.
- Red entry: `light`==3'b100 and the previous-cycle `light` was not 3'b100. The `light` history register resets to non-red, so red present at reset release counts as an entry.
- Any code other than the three legal codes sets `fault` (sticky until reset) and is treated as non-red.
- States:
  - DONT_WALK: `dont_walk`=1. On red entry with `req_pending`=1 (including a request latched that same cycle) → WALK; load countdown=WALK_TICKS, clear prescaler. A request latched while red is already active waits for the next red entry.
  - WALK: `walk`=1, `dont_walk`=0. The prescaler counts 0..TICK_DIV-1; countdown decrements on wrap. When countdown reaches 0 at a wrap → FLASH; load countdown=FLASH_TICKS, clear prescaler.
  - FLASH: `walk`=0; `dont_walk`=1 while prescaler < TICK_DIV/2, else 0. Countdown decrements as in WALK. At expiry → DONT_WALK and clear `req_pending`.
- Abort: in WALK or FLASH, if `light`≠3'b100 → DONT_WALK next cycle, `abort`=1 for that one cycle, countdown=0. `req_pending` stays set and is retried on the next red entry.
- Simultaneous events: abort has priority over tick expiry. A button edge during FLASH re-arms `req_pending` after the clear (set wins over clear).
- Outputs are registered. `walk` and `dont_walk` are never both 1.

## Timing
- Button → `req_pending`: 3 clock edges after `button` is first sampled high.
- Red entry → `walk`=1: 1 cycle. WALK lasts exactly WALK_TICKS·TICK_DIV cycles; FLASH lasts exactly FLASH_TICKS·TICK_DIV cycles.
- `countdown` shows N for the first tick of a phase, then N-1, …, down to 1.
- Abort response: 1 cycle after the non-red `light` is sampled.
- Reset is asynchronous assert and synchronous-safe deassert; a reset mid-WALK returns to reset values immediately.

## Structure
- Shared package `traffic_pkg`:
  - light code constants LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, also used by the upstream signal FSM
  - state enum ped_state_t {PED_DONT_WALK, PED_WALK, PED_FLASH}
- Sub-module `button_sync`: 2-flop synchroniser plus rising-edge pulse, with the same clock/reset.

## Test plan
Parameters: WALK_TICKS=3, FLASH_TICKS=2, TICK_DIV=4.
- Reset held, then released with `light`=green → `dont_walk`=1, all other outputs 0, state stays DONT_WALK.
- Button pulse during green, then `light`=red held 40 cycles → `walk`=1 one cycle after red for 12 cycles with countdown 3,2,1 (4 cycles each). Then FLASH for 8 cycles: countdown 2,1, `dont_walk` pattern 1,1,0,0,1,1,0,0. Then steady `dont_walk`=1 and `req_pending`=0.
- `light`=red with no request → no WALK, `countdown`=0 throughout.
- Request served, `light`→green 5 cycles into WALK → next cycle `dont_walk`=1, `abort` pulse of 1 cycle, `req_pending`=1. Next red entry → WALK again.
- Button pressed while red is already active → no WALK during that red. The next green→red transition starts WALK.
- `light`=3'b110 for one cycle → `fault`=1, which stays set. Then async `reset`=0 mid-WALK → immediately returns to reset values, including `fault`=0.
